i2c_condition_detector: RTL

//  Slave-side counterpart of the bus-master START/STOP generator. Oversamples raw SCL/SDA on
//  the system clock, synchronises and glitch-filters them, and detects START, repeated START
//  and STOP conditions. Tracks bus ownership (idle/busy) and counts bit positions within each

---
 rtl/i2c_condition_detector_if.sv | 28 ++
 rtl/i2c_condition_detector.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/i2c_condition_detector_if.sv
// Raw I2C line inputs, enable and decoded condition/bit strobes for the slave-side detector.
interface i2c_condition_detector_if;
    logic       enable;
    logic       scl_in;
    logic       sda_in;
    logic       start_det;
    logic       rstart_det;
    logic       stop_det;
    logic       timeout_det;
    logic       bus_busy;
    logic       scl_rise;
    logic       scl_fall;
    logic       sda_bit;
    logic [3:0] bit_cnt;
    logic       byte_done;

    modport master (
        output enable, scl_in, sda_in,
        input  start_det, rstart_det, stop_det, timeout_det, bus_busy,
               scl_rise, scl_fall, sda_bit, bit_cnt, byte_done
    );

    modport slave (
        input  enable, scl_in, sda_in,
        output start_det, rstart_det, stop_det, timeout_det, bus_busy,
               scl_rise, scl_fall, sda_bit, bit_cnt, byte_done
    );
endinterface

// File: rtl/i2c_condition_detector.sv
// Oversampling I2C START/repeated-START/STOP detector with glitch filter, bus-busy tracking
// and per-byte bit counter driving single-cycle strobes for a slave shift register.
module i2c_condition_detector #(
    parameter int unsigned FILTER_LEN   = 3,
    parameter int unsigned IDLE_TIMEOUT = 1000,
    parameter int unsigned TMO_W        = 16
) (
    input logic                     clk,
    input logic                     rst,
    i2c_condition_detector_if.slave bus
);

    localparam int unsigned FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    // Bit 0 = SCL, bit 1 = SDA throughout the front end.
    logic [1:0]     sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [FCW-1:0] fcnt_q [2];

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             armed_q;
    logic             start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
    logic             tmo_det_q, tmo_det_d, byte_done_q, byte_done_d;
    logic             scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic             sda_bit_q, sda_bit_d;

    logic scl_f, sda_f, rise_c, fall_c, start_c, stop_c, both_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            fcnt_q[0]   <= '0;
            fcnt_q[1]   <= '0;
        end else begin
            sync1_q     <= {bus.sda_in, bus.scl_in};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= ~filt_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FCW'(1);
                end
            end
        end
    end

    // SCL must be high in both cycles, so a same-cycle SCL/SDA toggle is only an SCL edge.
    always_comb begin
        scl_f   = filt_q[0];
        sda_f   = filt_q[1];
        rise_c  = scl_f & ~filt_prev_q[0];
        fall_c  = ~scl_f & filt_prev_q[0];
        start_c = scl_f & filt_prev_q[0] & filt_prev_q[1] & ~sda_f;
        stop_c  = scl_f & filt_prev_q[0] & ~filt_prev_q[1] & sda_f;
        both_hi = scl_f & sda_f;
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = '0;
        bit_cnt_d   = bit_cnt_q;
        start_d     = 1'b0;
        rstart_d    = 1'b0;
        stop_d      = 1'b0;
        tmo_det_d   = 1'b0;
        byte_done_d = 1'b0;
        scl_rise_d  = rise_c & bus.enable;
        scl_fall_d  = fall_c & bus.enable;
        sda_bit_d   = (rise_c && bus.enable) ? sda_f : sda_bit_q;

        if (!bus.enable) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = '0;
                    if (start_c && armed_q) begin
                        state_d = BUSY;
                        start_d = 1'b1;
                    end
                end
                BUSY: begin
                    if (start_c) begin
                        rstart_d  = 1'b1;
                        bit_cnt_d = '0;
                    end else if (stop_c) begin
                        stop_d    = 1'b1;
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        if (rise_c) begin
                            bit_cnt_d   = (bit_cnt_q == 4'd9) ? 4'd1 : bit_cnt_q + 4'd1;
                            byte_done_d = (bit_cnt_q == 4'd8);
                        end
                        if (both_hi) begin
                            if (tmo_q == TMO_W'(IDLE_TIMEOUT - 1)) begin
                                tmo_det_d   = 1'b1;
                                state_d     = IDLE;
                                bit_cnt_d   = '0;
                                byte_done_d = 1'b0;
                            end else begin
                                tmo_d = tmo_q + TMO_W'(1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            bit_cnt_q   <= '0;
            armed_q     <= 1'b0;
            start_q     <= 1'b0;
            rstart_q    <= 1'b0;
            stop_q      <= 1'b0;
            tmo_det_q   <= 1'b0;
            byte_done_q <= 1'b0;
            scl_rise_q  <= 1'b0;
            scl_fall_q  <= 1'b0;
            sda_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            bit_cnt_q   <= bit_cnt_d;
            armed_q     <= armed_q | both_hi;
            start_q     <= start_d;
            rstart_q    <= rstart_d;
            stop_q      <= stop_d;
            tmo_det_q   <= tmo_det_d;
            byte_done_q <= byte_done_d;
            scl_rise_q  <= scl_rise_d;
            scl_fall_q  <= scl_fall_d;
            sda_bit_q   <= sda_bit_d;
        end
    end

    assign bus.start_det   = start_q;
    assign bus.rstart_det  = rstart_q;
    assign bus.stop_det    = stop_q;
    assign bus.timeout_det = tmo_det_q;
    assign bus.bus_busy    = (state_q == BUSY);
    assign bus.scl_rise    = scl_rise_q;
    assign bus.scl_fall    = scl_fall_q;
    assign bus.sda_bit     = sda_bit_q;
    assign bus.bit_cnt     = bit_cnt_q;
    assign bus.byte_done   = byte_done_q;

endmodule
